// File: rtl/piso_shift_tx_pkg.sv
// Shared types and defaults for the PISO serial transmitter and its tick generator.
package piso_shift_tx_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SHIFT  = 2'd1,
    ST_PARITY = 2'd2,
    ST_DONE   = 2'd3
  } tx_state_e;

  localparam int DEFAULT_WIDTH = 8;
  localparam int DEFAULT_DIV   = 4;

  // Bits needed to hold 0..max_val, never less than one bit so DIV=1 still gets a legal vector.
  function automatic int cnt_width(input int max_val);
    int w;
    w = $clog2(max_val + 1);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/piso_shift_tx_tick_gen.sv
// Bit-period tick generator: pulses tick once every DIV clk cycles while run is high,
// and holds its counter at zero while run is low.
module piso_shift_tx_tick_gen
  import piso_shift_tx_pkg::*;
#(
  parameter int DIV = DEFAULT_DIV
) (
  input  logic clk,
  input  logic rst_n,
  input  logic run,
  output logic tick
);

  localparam int            CW   = cnt_width(DIV - 1);
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] cnt;

  assign tick = run && (cnt == LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (!run || tick) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CW'(1);
    end
  end

endmodule

// File: rtl/piso_shift_tx.sv
// Parallel-in serial-out transmitter, MSB first, one bit per DIV clk cycles.
// Optional feature: define TX_PARITY_EN to append one even-parity bit after the LSB.
module piso_shift_tx
  import piso_shift_tx_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int DIV   = DEFAULT_DIV
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] p_in,
  input  logic             load_valid,
  output logic             load_ready,
  output logic             s_out,
  output logic             s_valid,
  output logic             busy,
  output logic             done
);

  localparam int            BW       = cnt_width(WIDTH);
  localparam logic [BW-1:0] LAST_BIT = BW'(WIDTH - 1);

  tx_state_e        state;
  tx_state_e        state_next;
  logic [WIDTH-1:0] shift_reg;
  logic [BW-1:0]    bit_cnt;
  logic             tick;
  logic             accept;
  logic             run;
  logic             last_bit;
`ifdef TX_PARITY_EN
  logic             parity_bit;
`endif

  // Accept is decoded from the state directly so it does not loop through load_ready.
  assign accept   = load_valid && (state == ST_IDLE);
  assign run      = (state != ST_IDLE);
  assign last_bit = tick && (bit_cnt == LAST_BIT);

  piso_shift_tx_tick_gen #(
    .DIV (DIV)
  ) u_tick_gen (
    .clk   (clk),
    .rst_n (rst_n),
    .run   (run),
    .tick  (tick)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    load_ready = 1'b0;
    s_out      = 1'b0;
    s_valid    = 1'b0;
    busy       = 1'b0;
    done       = 1'b0;
    case (state)
      ST_IDLE: begin
        load_ready = 1'b1;
        if (load_valid) begin
          state_next = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        busy    = 1'b1;
        s_valid = 1'b1;
        s_out   = shift_reg[WIDTH-1];
        if (last_bit) begin
`ifdef TX_PARITY_EN
          state_next = ST_PARITY;
`else
          state_next = ST_DONE;
`endif
        end
      end
`ifdef TX_PARITY_EN
      ST_PARITY: begin
        busy    = 1'b1;
        s_valid = 1'b1;
        s_out   = parity_bit;
        if (tick) begin
          state_next = ST_DONE;
        end
      end
`endif
      ST_DONE: begin
        busy       = 1'b1;
        done       = 1'b1;
        state_next = ST_IDLE;
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  // Shift datapath: capture on accept, advance one bit on every tick while shifting.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shift_reg  <= '0;
      bit_cnt    <= '0;
`ifdef TX_PARITY_EN
      parity_bit <= 1'b0;
`endif
    end else if (accept) begin
      shift_reg  <= p_in;
      bit_cnt    <= '0;
`ifdef TX_PARITY_EN
      parity_bit <= ^p_in;
`endif
    end else if ((state == ST_SHIFT) && tick) begin
      shift_reg <= shift_reg << 1;
      bit_cnt   <= bit_cnt + BW'(1);
    end
  end

endmodule
